// File: rtl/multdiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | multdiv_seq : pipeline sequencer for a multi-cycle multiply/divide unit.
// |               Stalls the pipe, pulses the unit, waits for completion or
// |               timeout, then issues one writeback (result or status code).
// | Revision    : 1.0  initial release
// +----------------------------------------------------------------------------
module multdiv_seq #(
  parameter int TIMEOUT = 63
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] opcode,
  input  logic [4:0] aluop,
  input  logic       valid_x,
  input  logic [4:0] rd_x,
  input  logic       flush,
  input  logic       md_rdy,
  input  logic       md_exc,
  output logic       ctrl_mult,
  output logic       ctrl_div,
  output logic       stall,
  output logic       wb_en,
  output logic [4:0] wb_dest,
  output logic       wb_status,
  output logic [2:0] status_val,
  output logic       timeout
);

  localparam logic [5:0] c_tmo_last  = 6'(TIMEOUT - 1);
  localparam logic [4:0] c_rstatus   = 5'd30;
  localparam logic [4:0] c_aluop_mul = 5'd6;
  localparam logic [4:0] c_aluop_div = 5'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_cnt;
  logic [4:0] r_rd;
  logic       r_mult;
  logic       r_exc;
  logic       r_timeout;
  logic       w_decode;

  // Gated by reset_n so that stall stays low while reset is held.
  assign w_decode = reset_n & valid_x & (opcode == 5'd0) &
                    ((aluop == c_aluop_mul) | (aluop == c_aluop_div)) & ~flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_rd      <= 5'd0;
      r_mult    <= 1'b0;
      r_exc     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_decode) begin
            r_rd   <= rd_x;
            r_mult <= (aluop == c_aluop_mul);
          end
        end
        S_START: r_cnt <= 6'd0;
        S_BUSY: begin
          if (!flush) begin
            r_cnt <= r_cnt + 6'd1;
            // A ready response on the last allowed cycle beats the timeout.
            if (md_rdy) begin
              r_exc <= md_exc;
            end else if (r_cnt == c_tmo_last) begin
              r_exc     <= 1'b1;
              r_timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    stall      = 1'b0;
    wb_en      = 1'b0;
    wb_dest    = 5'd0;
    wb_status  = 1'b0;
    status_val = 3'd0;
    timeout    = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (w_decode) begin
          stall  = 1'b1;
          w_next = S_START;
        end
      end
      S_START: begin
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          ctrl_mult = r_mult;
          ctrl_div  = ~r_mult;
          stall     = 1'b1;
          w_next    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          stall = 1'b1;
          if (md_rdy || (r_cnt == c_tmo_last)) begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        wb_en      = 1'b1;
        wb_status  = r_exc;
        wb_dest    = r_exc ? c_rstatus : r_rd;
        status_val = r_exc ? (r_mult ? 3'd4 : 3'd5) : 3'd0;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_multdiv_seq : directed scoreboard bench for multdiv_seq.
// | Revision       : 1.0  initial release
// +----------------------------------------------------------------------------
module tb_multdiv_seq;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] opcode;
  logic [4:0] aluop;
  logic       valid_x;
  logic [4:0] rd_x;
  logic       flush;
  logic       md_rdy;
  logic       md_exc;
  logic       ctrl_mult;
  logic       ctrl_div;
  logic       stall;
  logic       wb_en;
  logic [4:0] wb_dest;
  logic       wb_status;
  logic [2:0] status_val;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] q_ctrl[$];
  logic [8:0] q_wb[$];

  multdiv_seq #(.TIMEOUT(63)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .aluop(aluop),
    .valid_x(valid_x), .rd_x(rd_x), .flush(flush), .md_rdy(md_rdy),
    .md_exc(md_exc), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .stall(stall), .wb_en(wb_en), .wb_dest(wb_dest), .wb_status(wb_status),
    .status_val(status_val), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: consumes one expectation per observed pulse.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (ctrl_mult || ctrl_div) begin
        n_chk++;
        if (q_ctrl.size() == 0) begin
          n_fail++;
          $display("FAIL ctrl_unexpected: got %b expected no pulse", {ctrl_mult, ctrl_div});
        end else begin
          logic [1:0] e;
          e = q_ctrl.pop_front();
          if ({ctrl_mult, ctrl_div} !== e) begin
            n_fail++;
            $display("FAIL ctrl_pulse: got %b expected %b", {ctrl_mult, ctrl_div}, e);
          end
        end
      end
      if (wb_en) begin
        n_chk++;
        if (q_wb.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected: got dest=%0d st=%b val=%0d expected no writeback",
                   wb_dest, wb_status, status_val);
        end else begin
          logic [8:0] e;
          e = q_wb.pop_front();
          if ({wb_dest, wb_status, status_val} !== e) begin
            n_fail++;
            $display("FAIL wb_data: got dest=%0d st=%b val=%0d expected dest=%0d st=%b val=%0d",
                     wb_dest, wb_status, status_val, e[8:4], e[3], e[2:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    opcode  = 5'd0;
    aluop   = 5'd0;
    valid_x = 1'b0;
    rd_x    = 5'd0;
    flush   = 1'b0;
    md_rdy  = 1'b0;
    md_exc  = 1'b0;
  endtask

  // Full operation with md_rdy in BUSY cycle rdy_at; md_rdy/md_exc are driven
  // high during START (must be ignored) and a flush plus a new mult are
  // presented during DONE (must be ignored / not re-issued).
  task automatic run_op(input logic m, input logic [4:0] rd, input int rdy_at,
                        input logic exc, input logic [4:0] e_dest,
                        input logic e_st, input logic [2:0] e_val);
    tick();
    idle_inputs();
    valid_x = 1'b1;
    aluop   = m ? 5'd6 : 5'd7;
    rd_x    = rd;
    q_ctrl.push_back(m ? 2'b10 : 2'b01);
    q_wb.push_back({e_dest, e_st, e_val});
    @(negedge clock);
    chk("issue_stall", stall, 1);
    tick();
    idle_inputs();
    md_rdy = 1'b1;
    md_exc = 1'b1;
    @(negedge clock);
    chk("start_stall", stall, 1);
    for (int k = 1; k <= rdy_at; k++) begin
      tick();
      idle_inputs();
      md_rdy = (k == rdy_at);
      md_exc = (k == rdy_at) ? exc : 1'b0;
      @(negedge clock);
      chk("busy_stall", stall, 1);
    end
    tick();
    idle_inputs();
    valid_x = 1'b1;
    aluop   = 5'd6;
    rd_x    = 5'd3;
    flush   = 1'b1;
    @(negedge clock);
    chk("done_stall", stall, 0);
    chk("done_wb_en", wb_en, 1);
    tick();
    idle_inputs();
    @(negedge clock);
    chk("after_done_stall", stall, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    valid_x = 1'b1;
    aluop   = 5'd6;
    rd_x    = 5'd4;
    @(negedge clock);
    chk("reset_outputs",
        {ctrl_mult, ctrl_div, stall, wb_en, wb_dest, wb_status, status_val, timeout}, 0);
    tick();
    idle_inputs();
    reset_n = 1'b1;

    // Basic mult, rd=5, ready in 2nd BUSY cycle
    run_op(1'b1, 5'd5, 2, 1'b0, 5'd5, 1'b0, 3'd0);
    // Div exception -> status write
    run_op(1'b0, 5'd9, 1, 1'b1, 5'd30, 1'b1, 3'd5);
    // Mult exception
    run_op(1'b1, 5'd12, 3, 1'b1, 5'd30, 1'b1, 3'd4);
    // rd=0 still writes back to r0
    run_op(1'b1, 5'd0, 1, 1'b0, 5'd0, 1'b0, 3'd0);
    // Ready on the last allowed BUSY cycle beats the timeout
    run_op(1'b0, 5'd17, 63, 1'b0, 5'd17, 1'b0, 3'd0);
    @(negedge clock);
    chk("no_timeout_on_last_rdy", timeout, 0);

    // Non-issuing instructions
    tick(); idle_inputs(); valid_x = 1'b1; aluop = 5'd0;
    @(negedge clock); chk("add_no_stall", stall, 0);
    tick(); idle_inputs(); valid_x = 1'b1; opcode = 5'd5; aluop = 5'd6;
    @(negedge clock); chk("addi_no_stall", stall, 0);
    tick(); idle_inputs(); aluop = 5'd7;
    @(negedge clock); chk("bubble_no_stall", stall, 0);
    tick(); idle_inputs(); valid_x = 1'b1; aluop = 5'd6; flush = 1'b1;
    @(negedge clock); chk("issue_flush_stall", stall, 0);
    tick(); idle_inputs();
    @(negedge clock); chk("issue_flush_next", stall, 0);

    // Flush during START: no ctrl pulse, no writeback
    tick(); idle_inputs(); valid_x = 1'b1; aluop = 5'd6; rd_x = 5'd2;
    @(negedge clock); chk("fs_issue_stall", stall, 1);
    tick(); idle_inputs(); flush = 1'b1;
    @(negedge clock); chk("fs_start_stall", stall, 0);
    tick(); idle_inputs();
    @(negedge clock); chk("fs_idle_stall", stall, 0);

    // Div flushed in 3rd BUSY cycle, then mult issued immediately
    tick(); idle_inputs(); valid_x = 1'b1; aluop = 5'd7; rd_x = 5'd8;
    q_ctrl.push_back(2'b01);
    @(negedge clock); chk("fb_issue_stall", stall, 1);
    tick(); idle_inputs();
    @(negedge clock); chk("fb_start_stall", stall, 1);
    for (int k = 1; k <= 2; k++) begin
      tick(); idle_inputs();
      @(negedge clock); chk("fb_busy_stall", stall, 1);
    end
    tick(); idle_inputs(); flush = 1'b1;
    @(negedge clock); chk("fb_flush_stall", stall, 0);
    run_op(1'b1, 5'd7, 1, 1'b0, 5'd7, 1'b0, 3'd0);

    // Timeout: 63 BUSY cycles without md_rdy
    tick(); idle_inputs(); valid_x = 1'b1; aluop = 5'd6; rd_x = 5'd11;
    q_ctrl.push_back(2'b10);
    q_wb.push_back({5'd30, 1'b1, 3'd4});
    @(negedge clock); chk("to_issue_stall", stall, 1);
    tick(); idle_inputs();
    @(negedge clock); chk("to_start_stall", stall, 1);
    for (int k = 1; k <= 63; k++) begin
      tick(); idle_inputs();
      @(negedge clock); chk("to_busy_stall", stall, 1);
    end
    chk("to_flag_before", timeout, 0);
    tick(); idle_inputs();
    @(negedge clock);
    chk("to_done_stall", stall, 0);
    chk("to_done_wb_en", wb_en, 1);
    chk("to_flag_set", timeout, 1);
    for (int k = 0; k < 4; k++) begin
      tick(); idle_inputs();
      @(negedge clock); chk("to_flag_sticky", timeout, 1);
    end

    // Reset mid-BUSY: asynchronous clear, no writeback afterwards
    tick(); idle_inputs(); valid_x = 1'b1; aluop = 5'd6; rd_x = 5'd6;
    q_ctrl.push_back(2'b10);
    @(negedge clock); chk("rs_issue_stall", stall, 1);
    tick(); idle_inputs();
    tick();
    @(negedge clock); chk("rs_busy_stall", stall, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_async_outputs",
        {ctrl_mult, ctrl_div, stall, wb_en, wb_dest, wb_status, status_val, timeout}, 0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); idle_inputs(); md_rdy = 1'b1;
      @(negedge clock); chk("rs_post_stall", stall, 0);
    end
    run_op(1'b0, 5'd21, 2, 1'b0, 5'd21, 1'b0, 3'd0);

    tick(); idle_inputs();
    @(negedge clock);
    chk("wb_queue_empty", q_wb.size(), 0);
    chk("ctrl_queue_empty", q_ctrl.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
